// File: rtl/xz_log_pkg.sv
// Shared types and helpers for the X/Z event logger.
// The signal count and timestamp width are set here so that the event struct
// and every port that carries its fields always have the same widths.
// Optional feature macro: XZ_LOG_KIND_EN (adds a per-event Z mask).
package xz_log_pkg;

    localparam int unsigned NUM_SIG = 8;
    localparam int unsigned TS_W    = 16;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
`ifdef XZ_LOG_KIND_EN
        logic [NUM_SIG-1:0] zmask;
`endif
        logic [NUM_SIG-1:0] mask;
        logic [TS_W-1:0]    ts;
    } evt_t;

    localparam int unsigned EVT_W = $bits(evt_t);

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/xz_log_fifo.sv
// First-word fall-through FIFO with registered head/valid, synchronous clear,
// and acceptance of a push into a full FIFO when a pop happens on the same edge.
module xz_log_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_head,
    output logic         o_accept_c,
    output logic         o_drop_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [AW-1:0] w_wptr_nxt;
    logic [AW-1:0] w_rptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [W-1:0]  w_head_nxt;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;

    // Push/pop decisions and the next head, so head/valid can be registered.
    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == CW'(DEPTH));
        w_pop       = i_pop && !w_empty && !i_clr;
        o_accept_c  = i_push && !i_clr && (!w_full || w_pop);
        o_drop_c    = i_push && !i_clr && w_full && !w_pop;
        w_wptr_nxt  = r_wptr + AW'(o_accept_c);
        w_rptr_nxt  = r_rptr + AW'(w_pop);
        w_count_nxt = r_count + CW'(o_accept_c) - CW'(w_pop);
        if (i_clr) begin
            w_wptr_nxt  = '0;
            w_rptr_nxt  = '0;
            w_count_nxt = '0;
        end
        // A write landing on the next read slot is the sole entry: forward it.
        if (w_count_nxt == '0) begin
            w_head_nxt = '0;
        end else if (o_accept_c && (r_wptr == w_rptr_nxt)) begin
            w_head_nxt = i_data;
        end else begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    // Pointers, occupancy and the registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            o_valid <= 1'b0;
            o_head  <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            o_valid <= (w_count_nxt != '0);
            o_head  <= w_head_nxt;
        end
    end

    // Storage array; contents are only read once written.
    always_ff @(posedge clk) begin
        if (o_accept_c) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule

// File: rtl/xz_event_logger.sv
// Samples monitored signals each cycle, logs cycles with X/Z bits as
// {mask, timestamp} events into a FIFO drained over valid/ready, and keeps
// saturating accept/drop counters plus a sticky overflow flag.
// Optional feature macro: XZ_LOG_KIND_EN (adds evt_zmask, Z-only bits).
// Detection uses 4-state case equality and is meant for simulation use.
module xz_event_logger
    import xz_log_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mon_en,
    input  logic [NUM_SIG-1:0] mon_sig,
    input  logic               clr,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [NUM_SIG-1:0] evt_mask,
    output logic [TS_W-1:0]    evt_ts,
`ifdef XZ_LOG_KIND_EN
    output logic [NUM_SIG-1:0] evt_zmask,
`endif
    output logic [CNT_W-1:0]   evt_cnt,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               overflow
);

    logic [NUM_SIG-1:0] w_unk;
    logic               w_push;
    logic               w_accept;
    logic               w_drop;
    logic [TS_W-1:0]    r_ts;
    evt_t               w_evt_in;
    evt_t               w_evt_head;

    // Flag every bit that is neither a clean 0 nor a clean 1.
    always_comb begin
        w_unk = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            w_unk[i] = !((mon_sig[i] === 1'b0) || (mon_sig[i] === 1'b1));
        end
    end

`ifdef XZ_LOG_KIND_EN
    logic [NUM_SIG-1:0] w_zed;

    // Separate out bits that are specifically high-impedance.
    always_comb begin
        w_zed = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            w_zed[i] = (mon_sig[i] === 1'bz);
        end
    end
`endif

    assign w_push = mon_en && (w_unk != '0);

    // Event payload captured at this sample.
    always_comb begin
        w_evt_in      = '0;
        w_evt_in.mask = w_unk;
        w_evt_in.ts   = r_ts;
`ifdef XZ_LOG_KIND_EN
        w_evt_in.zmask = w_zed;
`endif
    end

    xz_log_fifo #(
        .W     (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (clr),
        .i_push     (w_push),
        .i_data     (w_evt_in),
        .i_pop      (evt_ready),
        .o_valid    (evt_valid),
        .o_head     (w_evt_head),
        .o_accept_c (w_accept),
        .o_drop_c   (w_drop)
    );

    assign evt_mask = w_evt_head.mask;
    assign evt_ts   = w_evt_head.ts;
`ifdef XZ_LOG_KIND_EN
    assign evt_zmask = w_evt_head.zmask;
`endif

    // Free-running cycle counter used as the event timestamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else if (clr) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // Activity counters and sticky overflow, updated with the push decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            evt_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                evt_cnt <= sat_inc(evt_cnt);
            end
            if (w_drop) begin
                drop_cnt <= sat_inc(drop_cnt);
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xz_event_logger.sv
// Bench for xz_event_logger: table-driven vectors on the FIFO, directed
// sequences and randomized traffic on the top against a queue-based model.
// Optional feature macro: XZ_LOG_KIND_EN.
module tb_xz_event_logger;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mon_en;
    logic [7:0]  mon_sig;
    logic        clr;
    logic        evt_valid;
    logic        evt_ready;
    logic [7:0]  evt_mask;
    logic [15:0] evt_ts;
    logic [15:0] evt_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;
`ifdef XZ_LOG_KIND_EN
    logic [7:0]  evt_zmask;
`endif

    // Direct FIFO instance for table vectors.
    logic       f_push, f_pop, f_clr;
    logic [7:0] f_data;
    logic       f_valid, f_acc, f_drop;
    logic [7:0] f_head;

    int n_err = 0;
    int n_chk = 0;
    bit x_ok;

    always #5 clk = ~clk;

    xz_event_logger #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mon_en    (mon_en),
        .mon_sig   (mon_sig),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_mask  (evt_mask),
        .evt_ts    (evt_ts),
`ifdef XZ_LOG_KIND_EN
        .evt_zmask (evt_zmask),
`endif
        .evt_cnt   (evt_cnt),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    xz_log_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (f_clr),
        .i_push     (f_push),
        .i_data     (f_data),
        .i_pop      (f_pop),
        .o_valid    (f_valid),
        .o_head     (f_head),
        .o_accept_c (f_acc),
        .o_drop_c   (f_drop)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]  mask;
        logic [7:0]  zmask;
        logic [15:0] ts;
    } mevt_t;

    mevt_t       q[$];
    logic [15:0] m_ts;
    int          m_evt, m_drop;
    bit          m_ovf;

    function automatic logic [7:0] unk_of(input logic [7:0] s);
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) r[i] = (s[i] !== 1'b0) && (s[i] !== 1'b1);
        return r;
    endfunction

    function automatic logic [7:0] zed_of(input logic [7:0] s);
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) r[i] = (s[i] === 1'bz);
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ts = '0; m_evt = 0; m_drop = 0; m_ovf = 0;
    endtask

    // What one rising edge does, given the inputs currently applied.
    task automatic model_edge();
        bit    pop, push;
        mevt_t e;
        if (clr === 1'b1) begin
            model_reset();
        end else begin
            pop  = (q.size() != 0) && (evt_ready === 1'b1);
            push = (mon_en === 1'b1) && (unk_of(mon_sig) != 0);
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) begin
                    e.mask = unk_of(mon_sig); e.zmask = zed_of(mon_sig); e.ts = m_ts;
                    q.push_back(e);
                    if (m_evt < 65535) m_evt++;
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_ovf = 1;
                end
            end
            m_ts = m_ts + 16'd1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit e = (q.size() == 0);
        chk("evt_valid", 32'(evt_valid), e ? 32'd0 : 32'd1);
        chk("evt_mask", 32'(evt_mask), e ? 32'd0 : 32'(q[0].mask));
        chk("evt_ts", 32'(evt_ts), e ? 32'd0 : 32'(q[0].ts));
`ifdef XZ_LOG_KIND_EN
        chk("evt_zmask", 32'(evt_zmask), e ? 32'd0 : 32'(q[0].zmask));
`endif
        chk("evt_cnt", 32'(evt_cnt), 32'(m_evt));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // One clock: inputs were set at the previous falling edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clr_cycle();
        clr = 1'b1; cycle(); clr = 1'b0;
    endtask

    function automatic logic [7:0] rnd_sig();
        logic [7:0] s;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 19))
                0:       s[i] = 1'bx;
                1:       s[i] = 1'bz;
                default: s[i] = 1'($urandom_range(0, 1));
            endcase
        end
        return s;
    endfunction

    // ---------------- FIFO vector table ----------------
    typedef struct {
        logic       push, pop, clr;
        logic [7:0] data;
        logic       acc, drop, valid;
        logic [7:0] head;
    } fvec_t;

    fvec_t ftab[16];

    function automatic fvec_t fv(input logic pu, po, cl, input logic [7:0] d,
                                 input logic a, dr, v, input logic [7:0] h);
        fvec_t r;
        r.push = pu; r.pop = po; r.clr = cl; r.data = d;
        r.acc = a; r.drop = dr; r.valid = v; r.head = h;
        return r;
    endfunction

    initial begin
        logic       probe;
        logic [7:0] v;

        probe = 1'bx;
        x_ok  = (probe !== 1'b0) && (probe !== 1'b1);

        rst_n = 1'b0; mon_en = 1'b0; mon_sig = '0; clr = 1'b0; evt_ready = 1'b0;
        f_push = 1'b0; f_pop = 1'b0; f_clr = 1'b0; f_data = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        chk("fifo_rst_valid", 32'(f_valid), 32'd0);

        //               push pop clr data   acc drop valid head
        ftab[0]  = fv(1, 0, 0, 8'hA1, 1, 0, 1, 8'hA1);
        ftab[1]  = fv(1, 0, 0, 8'hA2, 1, 0, 1, 8'hA1);
        ftab[2]  = fv(1, 0, 0, 8'hA3, 1, 0, 1, 8'hA1);
        ftab[3]  = fv(1, 0, 0, 8'hA4, 1, 0, 1, 8'hA1);
        ftab[4]  = fv(1, 0, 0, 8'hA5, 0, 1, 1, 8'hA1);
        ftab[5]  = fv(1, 1, 0, 8'hA6, 1, 0, 1, 8'hA2);
        ftab[6]  = fv(0, 1, 0, 8'h00, 0, 0, 1, 8'hA3);
        ftab[7]  = fv(0, 1, 0, 8'h00, 0, 0, 1, 8'hA4);
        ftab[8]  = fv(0, 1, 0, 8'h00, 0, 0, 1, 8'hA6);
        ftab[9]  = fv(0, 1, 0, 8'h00, 0, 0, 0, 8'h00);
        ftab[10] = fv(0, 1, 0, 8'h00, 0, 0, 0, 8'h00);
        ftab[11] = fv(1, 1, 0, 8'hB1, 1, 0, 1, 8'hB1);
        ftab[12] = fv(1, 0, 1, 8'hB2, 0, 0, 0, 8'h00);
        ftab[13] = fv(1, 0, 0, 8'hC1, 1, 0, 1, 8'hC1);
        ftab[14] = fv(1, 1, 0, 8'hC2, 1, 0, 1, 8'hC2);
        ftab[15] = fv(0, 1, 0, 8'h00, 0, 0, 0, 8'h00);

        for (int i = 0; i < 16; i++) begin
            f_push = ftab[i].push; f_pop = ftab[i].pop; f_clr = ftab[i].clr; f_data = ftab[i].data;
            #1;
            chk($sformatf("fifo_acc[%0d]", i), 32'(f_acc), 32'(ftab[i].acc));
            chk($sformatf("fifo_drop[%0d]", i), 32'(f_drop), 32'(ftab[i].drop));
            @(posedge clk); #1;
            chk($sformatf("fifo_valid[%0d]", i), 32'(f_valid), 32'(ftab[i].valid));
            chk($sformatf("fifo_head[%0d]", i), 32'(f_head), 32'(ftab[i].head));
            @(negedge clk);
        end
        f_push = 1'b0; f_pop = 1'b0; f_clr = 1'b0;

        // Clean run: toggling clean values never log anything.
        clr_cycle();
        mon_en = 1'b1; evt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mon_sig = (i % 2 == 0) ? 8'h55 : 8'hAA;
            cycle();
        end
        chk("clean_evt_cnt", 32'(evt_cnt), 32'd0);

        // Single X on bit 2 sampled while ts = 5.
        mon_sig = '0;
        clr_cycle();
        for (int i = 0; i < 5; i++) cycle();
        v = 8'h00; v[2] = 1'bx; mon_sig = v;
        evt_ready = 1'b0;
        cycle();
        mon_sig = '0;
        if (x_ok) begin
            chk("single_valid", 32'(evt_valid), 32'd1);
            chk("single_mask", 32'(evt_mask), 32'h04);
            chk("single_ts", 32'(evt_ts), 32'd5);
        end
        evt_ready = 1'b1;
        cycle();
        if (x_ok) chk("single_cnt", 32'(evt_cnt), 32'd1);

        // Overflow: 6 samples into a 4-deep FIFO with no drain.
        clr_cycle();
        evt_ready = 1'b0;
        v = 8'h00; v[0] = 1'bx; mon_sig = v;
        for (int i = 0; i < 6; i++) cycle();
        if (x_ok) begin
            chk("ovf_drop", 32'(drop_cnt), 32'd2);
            chk("ovf_flag", 32'(overflow), 32'd1);
            chk("ovf_cnt", 32'(evt_cnt), 32'd4);
        end
        // Full with pop on the same edge: push accepted, nothing dropped.
        evt_ready = 1'b1;
        cycle();
        if (x_ok) begin
            chk("fullpop_drop", 32'(drop_cnt), 32'd2);
            chk("fullpop_cnt", 32'(evt_cnt), 32'd5);
            chk("fullpop_ts", 32'(evt_ts), 32'd1);
        end
        mon_sig = '0;
        for (int i = 0; i < 5; i++) cycle();

        // Gating: mon_en low suppresses detection.
        mon_en = 1'b0; mon_sig = v;
        for (int i = 0; i < 3; i++) cycle();
        chk("gate_valid", 32'(evt_valid), 32'd0);

        // clr with X present and entries pending wipes everything.
        mon_en = 1'b1; evt_ready = 1'b0;
        for (int i = 0; i < 2; i++) cycle();
        evt_ready = 1'b1;
        clr_cycle();
        mon_sig = '0;
        chk("clr_valid", 32'(evt_valid), 32'd0);
        chk("clr_cnt", 32'(evt_cnt), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Reset mid-drain: outputs drop to zero without waiting for a clock.
        evt_ready = 1'b0; mon_sig = v;
        for (int i = 0; i < 3; i++) cycle();
        mon_sig = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_mask", 32'(evt_mask), 32'd0);
        chk("rst_ts", 32'(evt_ts), 32'd0);
        chk("rst_cnt", 32'(evt_cnt), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // Z on bit 7 is reported in evt_mask (and evt_zmask when present).
        v = 8'h00; v[7] = 1'bz; mon_sig = v;
        cycle();
        mon_sig = '0;
        if (x_ok) begin
            chk("z_mask", 32'(evt_mask), 32'h80);
`ifdef XZ_LOG_KIND_EN
            chk("z_zmask", 32'(evt_zmask), 32'h80);
`endif
        end
        evt_ready = 1'b1;
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            mon_en    = ($urandom_range(0, 9) < 7);
            mon_sig   = rnd_sig();
            evt_ready = ($urandom_range(0, 1) == 1);
            clr       = ($urandom_range(0, 39) == 0);
            cycle();
        end
        clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/xz_event_logger.md
# xz_event_logger

Simulation-side consumer stage for the never-unknown checks. Samples a vector of monitored signals every clock, detects which bits are X or Z, and records each offending cycle as an event (mask plus timestamp) in a small FIFO. A valid/ready port drains the FIFO to a scoreboard or reporting stage. Sticky overflow and saturating counters summarise activity between clears.

## Interface
- NUM_SIG, 8, number of monitored 1-bit signals
- DEPTH, 4, event FIFO entries (power of two, ≥2)
- TS_W, 16, timestamp (cycle counter) width
- clk  input  1  sampling clock; all state on posedge
- rst_n  input  1  reset, asynchronous assert, active-low
- mon_en  input  1  sampling enable; 0 = no detection this cycle
- mon_sig  input  NUM_SIG  signals under check
- clr  input  1  synchronous flush of FIFO, counters, sticky flags
- evt_valid  output  1  FIFO head holds an event
- evt_ready  input  1  consumer accepts head when high with evt_valid
- evt_mask  output  NUM_SIG  bit i = mon_sig[i] was X/Z at that sample
- evt_ts  output  TS_W  cycle-counter value at the sample
- evt_cnt  output  16  events accepted into FIFO, saturating at 16'hFFFF
- drop_cnt  output  16  events lost to full FIFO, saturating
- overflow  output  1  sticky: at least one event dropped since reset/clr

## Operation
- Per bit: unk[i] = 1 when mon_sig[i] is neither 1'b0 nor 1'b1 (X or Z); computed with 4-state case-equality, sim-only logic.
- Push request: mon_en && (unk != 0) at a posedge. Payload {unk, ts}.
- ts: free-running TS_W counter, increments every cycle after reset, wraps to 0 from all-ones; not affected by mon_en; cleared by clr.
- Pop: evt_valid && evt_ready at a posedge.
- FIFO not full: push accepted, evt_cnt +1 (saturating).
- FIFO full, no pop: push dropped, drop_cnt +1 (saturating), overflow set.
- FIFO full with pop same cycle: push accepted (slot freed same edge).
- FIFO empty with push: no bypass; event appears next cycle.
- clr: flushes FIFO, zeroes ts, evt_cnt, drop_cnt, overflow; any push or pop that cycle is ignored (clr has priority).
- Outputs evt_mask/evt_ts are FIFO head (first-word fall-through); 0 when empty.
- Reset (rst_n low, any time incl. mid-drain): FIFO empty, evt_valid=0, evt_mask=0, evt_ts=0, evt_cnt=0, drop_cnt=0, overflow=0, ts=0. Pending events are discarded.

## Timing
- Sample at posedge k -> evt_valid high after edge k (1-cycle latency), evt_ts = ts value during cycle k.
- Back-to-back events each cycle accepted while space remains; sustained throughput 1 event/cycle with evt_ready held high.
- evt_mask/evt_ts stable while evt_valid && !evt_ready.
- Counters/overflow update on the same edge as the push/drop decision.

## Configuration
- XZ_LOG_KIND_EN defined: extra output evt_zmask (NUM_SIG) stored per entry; bit i = 1 when mon_sig[i] was 1'bz, 0 when X or clean; reset/empty value 0.
- Undefined: port and storage absent; X and Z are reported identically in evt_mask.

## Structure
- Package xz_log_pkg: event struct typedef (mask, ts, optional zmask), CNT_W=16 constant, saturating-increment function.
- Sub-module xz_log_fifo: parameterised DEPTH synchronous FIFO with full/empty, clear, and same-cycle push-on-full-with-pop support; top holds detection, ts counter, counters.

## Test plan
- Clean run: mon_sig toggles 0/1 for 20 cycles, mon_en=1 -> evt_valid never high, evt_cnt=0.
- Single X: mon_sig[2]=X at cycle 5 (ts=5) -> next cycle evt_valid=1, evt_mask=8'h04, evt_ts=5; pop -> empty, evt_cnt=1.
- Overflow: DEPTH=4, evt_ready=0, X on bit 0 for 6 cycles -> 4 stored, drop_cnt=2, overflow=1; drain yields 4 events with consecutive ts.
- Full with pop: FIFO full, evt_ready=1 and new X same cycle -> accepted, drop_cnt unchanged, occupancy stays 4.
- Gating and clr: X present with mon_en=0 -> no event; clr with X and pending entries -> FIFO empty, all counters 0, overflow 0 next cycle.
- Reset mid-drain: 3 events queued, rst_n pulsed low asynchronously -> all outputs 0 immediately; with XZ_LOG_KIND_EN, mon_sig[7]=Z gives evt_mask=8'h80, evt_zmask=8'h80.
